// File: rtl/lot_pkg.sv
// Shared types and 7-segment constants for the parking-lot occupancy controller.
package lot_pkg;

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } gate_state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/seg7_decode.sv
// Single-digit BCD to active-low 7-segment decoder with a blanking input.
module seg7_decode
  import lot_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_DIGIT[0];
        4'd1:    seg_o = SEG_DIGIT[1];
        4'd2:    seg_o = SEG_DIGIT[2];
        4'd3:    seg_o = SEG_DIGIT[3];
        4'd4:    seg_o = SEG_DIGIT[4];
        4'd5:    seg_o = SEG_DIGIT[5];
        4'd6:    seg_o = SEG_DIGIT[6];
        4'd7:    seg_o = SEG_DIGIT[7];
        4'd8:    seg_o = SEG_DIGIT[8];
        4'd9:    seg_o = SEG_DIGIT[9];
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/lot_occupancy_ctrl.sv
// Parking-lot occupancy counter with full/empty flags, entry-gate sequencing
// and a two-digit 7-segment occupancy display.
module lot_occupancy_ctrl
  import lot_pkg::*;
#(
  parameter int CAP      = 25,
  parameter int GATE_CYC = 50,
  parameter int CW       = 7
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          enter,
  input  logic          exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          gate_open,
  output logic          reject,
  output logic [6:0]    HEX0,
  output logic [6:0]    HEX1
);

  localparam int TW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(GATE_CYC - 1);
  localparam logic [CW-1:0] CAP_CNT      = CW'(CAP);

  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, reject_q, gate_open_q;
  logic [TW-1:0] timer_q;
  gate_state_t   state_q;

  logic at_cap, at_zero, accept, refuse;

  // Simultaneous enter+exit is a net-zero move but still lets a car through the gate.
  always_comb begin
    at_cap  = (count_q == CAP_CNT);
    at_zero = (count_q == '0);
    accept  = enter && (exit || !at_cap);
    refuse  = enter && !exit && at_cap;
    count_d = count_q;
    if (enter && !exit && !at_cap) begin
      count_d = count_q + CW'(1);
    end else if (exit && !enter && !at_zero) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Rst) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      reject_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= (count_d == CAP_CNT);
      empty_q  <= (count_d == '0);
      reject_q <= refuse;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= CLOSED;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
    end else begin
      case (state_q)
        CLOSED: begin
          if (accept) begin
            state_q     <= OPEN;
            timer_q     <= TIMER_RELOAD;
            gate_open_q <= 1'b1;
          end
        end
        OPEN: begin
          if (accept) begin
            timer_q <= TIMER_RELOAD;
          end else if (timer_q == '0) begin
            state_q     <= CLOSED;
            gate_open_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q     <= CLOSED;
          gate_open_q <= 1'b0;
        end
      endcase
    end
  end

  logic [3:0] tens, ones;

  always_comb begin
    tens = 4'(int'(count_q) / 10);
    ones = 4'(int'(count_q) % 10);
  end

  seg7_decode u_hex1 (
    .digit_i (tens),
    .blank_i (tens == 4'd0),
    .seg_o   (HEX1)
  );

  seg7_decode u_hex0 (
    .digit_i (ones),
    .blank_i (1'b0),
    .seg_o   (HEX0)
  );

  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign reject    = reject_q;
  assign gate_open = gate_open_q;

endmodule

// File: tb/tb_lot_occupancy_ctrl.sv
// Directed bench: a CAP=3/GATE_CYC=4 instance for counting and gating,
// plus a CAP=25 instance for the two-digit display.
module tb_lot_occupancy_ctrl;

  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enter = 1'b0, exit_p = 1'b0;
  logic enter25 = 1'b0, exit25 = 1'b0;

  logic [CW-1:0] count, count25;
  logic          full, empty, gate_open, reject;
  logic          full25, empty25, gate25, reject25;
  logic [6:0]    hex0, hex1, hex0_25, hex1_25;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lot_occupancy_ctrl #(.CAP(3), .GATE_CYC(4), .CW(CW)) u_dut (
    .clk       (clk),
    .Rst       (rst),
    .enter     (enter),
    .exit      (exit_p),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .gate_open (gate_open),
    .reject    (reject),
    .HEX0      (hex0),
    .HEX1      (hex1)
  );

  lot_occupancy_ctrl #(.CAP(25), .GATE_CYC(50), .CW(CW)) u_dut25 (
    .clk       (clk),
    .Rst       (rst),
    .enter     (enter25),
    .exit      (exit25),
    .count     (count25),
    .full      (full25),
    .empty     (empty25),
    .gate_open (gate25),
    .reject    (reject25),
    .HEX0      (hex0_25),
    .HEX1      (hex1_25)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that updated them.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic en, input logic ex);
    enter  = en;
    exit_p = ex;
    step();
    enter  = 1'b0;
    exit_p = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_gate", 32'(gate_open), 0);
    check("rst_reject", 32'(reject), 0);
    check("rst_hex0", 32'(hex0), 32'(7'b1000000));
    check("rst_hex1", 32'(hex1), 32'(7'b1111111));

    // 2. Three entries, each opening the gate for exactly 4 cycles
    for (int i = 1; i <= 3; i++) begin
      pulse(1'b1, 1'b0);
      check($sformatf("enter%0d_count", i), 32'(count), 32'(i));
      check($sformatf("enter%0d_gate0", i), 32'(gate_open), 1);
      for (int c = 1; c <= 3; c++) begin
        step();
        check($sformatf("enter%0d_gate%0d", i, c), 32'(gate_open), 1);
      end
      step();
      check($sformatf("enter%0d_gate_closed", i), 32'(gate_open), 0);
      step();
    end
    check("full_at_cap", 32'(full), 1);
    check("empty_at_cap", 32'(empty), 0);
    check("hex0_three", 32'(hex0), 32'(7'b0110000));

    // 3. Entry while full is refused
    pulse(1'b1, 1'b0);
    check("refuse_reject", 32'(reject), 1);
    check("refuse_count", 32'(count), 3);
    check("refuse_gate", 32'(gate_open), 0);
    step();
    check("refuse_reject_clr", 32'(reject), 0);
    check("refuse_gate_after", 32'(gate_open), 0);
    pulse(1'b0, 1'b1);
    check("exit_count", 32'(count), 2);
    check("exit_full", 32'(full), 0);

    // 4. Exit at zero is ignored; enter+exit at CAP holds count but opens gate
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("drain_count", 32'(count), 0);
    check("drain_empty", 32'(empty), 1);
    pulse(1'b0, 1'b1);
    check("exit0_count", 32'(count), 0);
    check("exit0_empty", 32'(empty), 1);
    check("exit0_reject", 32'(reject), 0);
    repeat (3) pulse(1'b1, 1'b0);
    repeat (5) step();
    check("refill_count", 32'(count), 3);
    check("refill_gate", 32'(gate_open), 0);
    pulse(1'b1, 1'b1);
    check("both_count", 32'(count), 3);
    check("both_reject", 32'(reject), 0);
    check("both_full", 32'(full), 1);
    check("both_gate0", 32'(gate_open), 1);
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("both_gate%0d", c), 32'(gate_open), 1);
    end
    step();
    check("both_gate_closed", 32'(gate_open), 0);

    // 5. Two entries 2 cycles apart keep the gate open 6 cycles
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("pre_retrig_count", 32'(count), 1);
    pulse(1'b1, 1'b0);
    check("retrig_gate0", 32'(gate_open), 1);
    step();
    check("retrig_gate1", 32'(gate_open), 1);
    pulse(1'b1, 1'b0);
    check("retrig_gate2", 32'(gate_open), 1);
    check("retrig_count", 32'(count), 3);
    for (int c = 3; c <= 5; c++) begin
      step();
      check($sformatf("retrig_gate%0d", c), 32'(gate_open), 1);
    end
    step();
    check("retrig_gate_closed", 32'(gate_open), 0);

    // 6. Reset mid-operation, with a concurrent enter that must lose
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    check("pre_rst_count", 32'(count), 2);
    check("pre_rst_gate", 32'(gate_open), 1);
    rst   = 1'b1;
    enter = 1'b1;
    step();
    rst   = 1'b0;
    enter = 1'b0;
    check("midrst_count", 32'(count), 0);
    check("midrst_gate", 32'(gate_open), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_full", 32'(full), 0);
    check("midrst_hex1", 32'(hex1), 32'(7'b1111111));

    // Two-digit display on the CAP=25 instance
    for (int i = 0; i < 12; i++) begin
      enter25 = 1'b1;
      step();
      enter25 = 1'b0;
      if (i == 9) begin
        check("disp10_hex1", 32'(hex1_25), 32'(7'b1111001));
        check("disp10_hex0", 32'(hex0_25), 32'(7'b1000000));
      end
    end
    check("disp12_count", 32'(count25), 12);
    check("disp12_hex1", 32'(hex1_25), 32'(7'b1111001));
    check("disp12_hex0", 32'(hex0_25), 32'(7'b0100100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lot_occupancy_ctrl.md
Name: lot_occupancy_ctrl

Overview:
Consumes the one-cycle Enter/Exit pulses produced by the photo-sensor direction detector. Maintains the parking-lot occupancy count against a fixed capacity and sequences the entry gate. Rejects entries when the lot is full. Drives full/empty status and a two-digit active-low 7-segment occupancy display for the DE1_SoC top level.

Parameters:
CAP, 25, lot capacity in cars; legal range 1..99.
GATE_CYC, 50, number of cycles the entry gate stays open after an accepted entry; must be ≥1.
CW, 7, counter width; must satisfy 2**CW > CAP.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
Rst  in  1  synchronous, active-high reset.
enter  in  1  one-cycle pulse from the sensor block: a car has entered.
exit  in  1  one-cycle pulse from the sensor block: a car has exited.
count  out  CW  registered occupancy.
full  out  1  registered; 1 when count == CAP.
empty  out  1  registered; 1 when count == 0.
gate_open  out  1  registered; entry gate open command.
reject  out  1  registered one-cycle pulse: entry refused because the lot was full.
HEX0  out  7  active-low 7-seg, ones digit of count.
HEX1  out  7  active-low 7-seg, tens digit of count; blank (all 1s) when count < 10.

Behaviour:
- Reset, sampled on a clk edge while Rst=1:
  - count=0, empty=1, full=0, gate_open=0, reject=0, gate FSM=CLOSED, gate timer=0.
  - HEX0 shows "0"; HEX1 is blank.
- Rst has priority over enter and exit in the same cycle.
- Asserting Rst mid-operation (gate open, count nonzero) returns all state to reset values on that edge.
- Inputs are sampled each rising edge. All outputs update on the following edge, so pulse-to-output latency is 1 cycle.
- enter=1, exit=0:
  - count<CAP: count+1; the entry is accepted.
  - count==CAP: count held; reject=1 for exactly 1 cycle; the entry is not accepted.
- enter=0, exit=1:
  - count>0: count-1.
  - count==0: ignored; count stays 0; no flag raised.
- enter=1, exit=1 in the same cycle:
  - count unchanged at any count value, including 0 and CAP.
  - reject=0; this counts as an accepted entry for the gate FSM.
- full and empty are computed from the next count value and registered, so they are coincident with count.
- Count never wraps: it saturates at CAP and at 0.
- Gate FSM states:
  - CLOSED: gate_open=0. An accepted entry moves to OPEN and loads timer=GATE_CYC-1.
  - OPEN: gate_open=1. Each cycle with no accepted entry, the timer decrements. When timer==0 with no accepted entry, go to CLOSED on the next edge.
  - An accepted entry while OPEN reloads timer=GATE_CYC-1 and stays OPEN.
  - Rejected entries never open or extend the gate.
  - Result: a single accepted entry holds gate_open high for exactly GATE_CYC cycles.
- Display:
  - HEX1/HEX0 are combinational from registered count, via tens/ones split (count/10, count%10).
  - Segment encoding is active-low; segment order {g,f,e,d,c,b,a}.

Decomposition:
- Shared package lot_pkg:
  - gate_state_t enum {CLOSED, OPEN}.
  - 7-seg constants SEG_BLANK=7'b1111111 and the digit table 0-9.
- One sub-module, seg7_decode: 4-bit digit plus blank input, 7-bit active-low output; instantiated twice.
- Counter, flags and gate FSM remain in lot_occupancy_ctrl.

Test Plan:
(All scenarios use CAP=3, GATE_CYC=4.)
1. Rst held 3 cycles, then released → count=0, empty=1, full=0, gate_open=0, HEX0=7'b1000000, HEX1=7'b1111111.
2. Three enter pulses 6 cycles apart → count 1,2,3, each 1 cycle after its pulse; full=1 and empty=0 after the third; gate_open high 4 cycles after each pulse.
3. At count=3, enter pulse → reject=1 for 1 cycle, count stays 3, gate_open stays 0. Then exit pulse → count=2, full=0.
4. At count=0, exit pulse → count stays 0, empty stays 1. enter+exit together at count=3 → count stays 3, reject=0, gate_open rises for 4 cycles.
5. Two accepted entries 2 cycles apart from CLOSED → gate_open continuously high for 6 cycles (2+4), then low.
6. Rst asserted while gate_open=1 and count=2 → next edge count=0, gate_open=0, empty=1. Also with CAP=25: drive count to 12 → HEX1=7'b1111001 ("1"), HEX0=7'b0100100 ("2").
